jedro_1_alu_arbiter: RTL and testbench

- Shares the single registered ALU (1-cycle result latency) between two requesters:
  - port 0: the execute stage;
  - port 1: a secondary client, e.g. the branch-compare or address-generation unit.
- Per cycle it selects at most one request by round-robin and drives the ALU operand, select, destination and writeback inputs.
- It tracks the one in-flight operation and steers the ALU result back to the owning requester with a registered response-valid.
- It sits between issue logic and jedro_1_alu.

---
 rtl/jedro_1_alu_arbiter.sv | 175 +++++++++++++++++
 tb/tb_jedro_1_alu_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jedro_1_alu_arbiter.sv
// rtl/jedro_1_alu_arbiter.sv - round-robin arbiter sharing one registered ALU between two requesters
//
// Purpose:
//   Grants at most one of two requesters per cycle, drives the ALU inputs from
//   the granted port and steers the ALU result (one cycle later) back to the
//   owning requester with a per-port response valid.
//
// Ports:
//   clk_i, rstn_i        clock, synchronous active-low reset
//   flush_i              kills the in-flight response and blocks grants this cycle
//   reqN_*               request valid/ready handshake plus sel, operands, dest, wb
//   alu_*_o              operands/control to the ALU (all zero when nothing is granted)
//   alu_*_i              registered results from the ALU
//   rspN_valid_o         result on the shared rsp_* bus belongs to port N
//   rsp_*_o              shared response bus; rsp_wb_o gated by a live response
//
// Optional: define JEDRO_1_ALU_ARB_PERF_EN to add perf_grant0_o, perf_grant1_o
//   and perf_conflict_o (32-bit wrapping event counters).

module jedro_1_alu_arbiter #(
   parameter int ALU_OP_W = 4,
   parameter int DATA_W   = 32,
   parameter int RADDR_W  = 5
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                flush_i,
   input  logic                req0_valid_i,
   output logic                req0_ready_o,
   input  logic [ALU_OP_W-1:0] req0_sel_i,
   input  logic [DATA_W-1:0]   req0_op_a_i,
   input  logic [DATA_W-1:0]   req0_op_b_i,
   input  logic [RADDR_W-1:0]  req0_dest_addr_i,
   input  logic                req0_wb_i,
   input  logic                req1_valid_i,
   output logic                req1_ready_o,
   input  logic [ALU_OP_W-1:0] req1_sel_i,
   input  logic [DATA_W-1:0]   req1_op_a_i,
   input  logic [DATA_W-1:0]   req1_op_b_i,
   input  logic [RADDR_W-1:0]  req1_dest_addr_i,
   input  logic                req1_wb_i,
   output logic [ALU_OP_W-1:0] alu_sel_o,
   output logic [DATA_W-1:0]   alu_op_a_o,
   output logic [DATA_W-1:0]   alu_op_b_o,
   output logic [RADDR_W-1:0]  alu_dest_addr_o,
   output logic                alu_wb_o,
   input  logic [DATA_W-1:0]   alu_res_i,
   input  logic                alu_ops_eq_i,
   input  logic                alu_overflow_i,
   input  logic [RADDR_W-1:0]  alu_dest_addr_i,
   input  logic                alu_wb_i,
   output logic                rsp0_valid_o,
   output logic                rsp1_valid_o,
   output logic [DATA_W-1:0]   rsp_res_o,
   output logic                rsp_ops_eq_o,
   output logic                rsp_overflow_o,
   output logic [RADDR_W-1:0]  rsp_dest_addr_o,
   output logic                rsp_wb_o
`ifdef JEDRO_1_ALU_ARB_PERF_EN
   ,
   output logic [31:0]         perf_grant0_o,
   output logic [31:0]         perf_grant1_o,
   output logic [31:0]         perf_conflict_o
`endif
);

   logic r_rr_ptr;
   logic r_inflight_v;
   logic r_inflight_id;

   logic w_both_valid;
   logic w_grant_en;
   logic w_grant0;
   logic w_grant1;
   logic w_any_grant;
   logic w_granted_id;

   assign w_both_valid = req0_valid_i & req1_valid_i;
   // Reset is folded in here so nothing is granted while rstn_i is low.
   assign w_grant_en   = rstn_i & ~flush_i;

   always_comb begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      if (w_grant_en) begin
         if (w_both_valid) begin
            w_grant0 = ~r_rr_ptr;
            w_grant1 = r_rr_ptr;
         end else begin
            w_grant0 = req0_valid_i;
            w_grant1 = req1_valid_i;
         end
      end
   end

   assign w_any_grant  = w_grant0 | w_grant1;
   assign w_granted_id = w_grant1;
   assign req0_ready_o = w_grant0;
   assign req1_ready_o = w_grant1;

   // Idle ALU inputs are forced to zero so an ungranted cycle can never write back.
   always_comb begin
      alu_sel_o       = '0;
      alu_op_a_o      = '0;
      alu_op_b_o      = '0;
      alu_dest_addr_o = '0;
      alu_wb_o        = 1'b0;
      if (w_grant0) begin
         alu_sel_o       = req0_sel_i;
         alu_op_a_o      = req0_op_a_i;
         alu_op_b_o      = req0_op_b_i;
         alu_dest_addr_o = req0_dest_addr_i;
         alu_wb_o        = req0_wb_i;
      end else if (w_grant1) begin
         alu_sel_o       = req1_sel_i;
         alu_op_a_o      = req1_op_a_i;
         alu_op_b_o      = req1_op_b_i;
         alu_dest_addr_o = req1_dest_addr_i;
         alu_wb_o        = req1_wb_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_rr_ptr      <= 1'b0;
         r_inflight_v  <= 1'b0;
         r_inflight_id <= 1'b0;
      end else begin
         // Favour the other port after any grant; hold otherwise.
         if (w_any_grant) begin
            r_rr_ptr <= ~w_granted_id;
         end
         r_inflight_v  <= w_any_grant & ~flush_i;
         r_inflight_id <= w_granted_id;
      end
   end

   // flush_i also kills the response already coming out of the ALU this cycle.
   assign rsp0_valid_o    = r_inflight_v & ~r_inflight_id & ~flush_i;
   assign rsp1_valid_o    = r_inflight_v &  r_inflight_id & ~flush_i;
   assign rsp_res_o       = alu_res_i;
   assign rsp_ops_eq_o    = alu_ops_eq_i;
   assign rsp_overflow_o  = alu_overflow_i;
   assign rsp_dest_addr_o = alu_dest_addr_i;
   assign rsp_wb_o        = alu_wb_i & (rsp0_valid_o | rsp1_valid_o);

`ifdef JEDRO_1_ALU_ARB_PERF_EN
   logic [31:0] r_perf_grant0;
   logic [31:0] r_perf_grant1;
   logic [31:0] r_perf_conflict;

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_perf_grant0   <= '0;
         r_perf_grant1   <= '0;
         r_perf_conflict <= '0;
      end else begin
         if (w_grant0) begin
            r_perf_grant0 <= r_perf_grant0 + 32'd1;
         end
         if (w_grant1) begin
            r_perf_grant1 <= r_perf_grant1 + 32'd1;
         end
         if (w_both_valid & ~flush_i) begin
            r_perf_conflict <= r_perf_conflict + 32'd1;
         end
      end
   end

   assign perf_grant0_o   = r_perf_grant0;
   assign perf_grant1_o   = r_perf_grant1;
   assign perf_conflict_o = r_perf_conflict;
`endif

endmodule

// File: tb/tb_jedro_1_alu_arbiter.sv
// tb/tb_jedro_1_alu_arbiter.sv - directed self-checking bench for jedro_1_alu_arbiter

module tb_jedro_1_alu_arbiter;

   localparam int ALU_OP_W = 4;
   localparam int DATA_W   = 32;
   localparam int RADDR_W  = 5;

   logic                clk = 1'b0;
   logic                rstn;
   logic                flush;
   logic                req0_valid, req1_valid;
   logic                req0_ready, req1_ready;
   logic [ALU_OP_W-1:0] req0_sel, req1_sel;
   logic [DATA_W-1:0]   req0_a, req0_b, req1_a, req1_b;
   logic [RADDR_W-1:0]  req0_dest, req1_dest;
   logic                req0_wb, req1_wb;
   logic [ALU_OP_W-1:0] alu_sel;
   logic [DATA_W-1:0]   alu_a, alu_b;
   logic [RADDR_W-1:0]  alu_dest;
   logic                alu_wb;
   logic [DATA_W-1:0]   m_res;
   logic                m_eq, m_ovf;
   logic [RADDR_W-1:0]  m_dest;
   logic                m_wb;
   logic                rsp0_valid, rsp1_valid;
   logic [DATA_W-1:0]   rsp_res;
   logic                rsp_eq, rsp_ovf;
   logic [RADDR_W-1:0]  rsp_dest;
   logic                rsp_wb;
`ifdef JEDRO_1_ALU_ARB_PERF_EN
   logic [31:0]         perf_g0, perf_g1, perf_cf;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   jedro_1_alu_arbiter #(.ALU_OP_W(ALU_OP_W), .DATA_W(DATA_W), .RADDR_W(RADDR_W)) dut (
      .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
      .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_sel_i(req0_sel),
      .req0_op_a_i(req0_a), .req0_op_b_i(req0_b), .req0_dest_addr_i(req0_dest), .req0_wb_i(req0_wb),
      .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_sel_i(req1_sel),
      .req1_op_a_i(req1_a), .req1_op_b_i(req1_b), .req1_dest_addr_i(req1_dest), .req1_wb_i(req1_wb),
      .alu_sel_o(alu_sel), .alu_op_a_o(alu_a), .alu_op_b_o(alu_b),
      .alu_dest_addr_o(alu_dest), .alu_wb_o(alu_wb),
      .alu_res_i(m_res), .alu_ops_eq_i(m_eq), .alu_overflow_i(m_ovf),
      .alu_dest_addr_i(m_dest), .alu_wb_i(m_wb),
      .rsp0_valid_o(rsp0_valid), .rsp1_valid_o(rsp1_valid), .rsp_res_o(rsp_res),
      .rsp_ops_eq_o(rsp_eq), .rsp_overflow_o(rsp_ovf), .rsp_dest_addr_o(rsp_dest), .rsp_wb_o(rsp_wb)
`ifdef JEDRO_1_ALU_ARB_PERF_EN
      , .perf_grant0_o(perf_g0), .perf_grant1_o(perf_g1), .perf_conflict_o(perf_cf)
`endif
   );

   // Registered ALU stand-in: sel 0 = ADD (overflow = carry out), sel 1 = SUB, else XOR.
   logic [DATA_W:0] m_sum;
   assign m_sum = {1'b0, alu_a} + {1'b0, alu_b};

   always_ff @(posedge clk) begin
      if (!rstn) begin
         m_res <= '0; m_eq <= 1'b0; m_ovf <= 1'b0; m_dest <= '0; m_wb <= 1'b0;
      end else begin
         case (alu_sel)
            4'd0:    begin m_res <= m_sum[DATA_W-1:0]; m_ovf <= m_sum[DATA_W]; end
            4'd1:    begin m_res <= alu_a - alu_b;     m_ovf <= 1'b0; end
            default: begin m_res <= alu_a ^ alu_b;     m_ovf <= 1'b0; end
         endcase
         m_eq   <= (alu_a == alu_b);
         m_dest <= alu_dest;
         m_wb   <= alu_wb;
      end
   end

   task automatic idle_inputs();
      req0_valid = 1'b0; req0_sel = '0; req0_a = '0; req0_b = '0; req0_dest = '0; req0_wb = 1'b0;
      req1_valid = 1'b0; req1_sel = '0; req1_a = '0; req1_b = '0; req1_dest = '0; req1_wb = 1'b0;
      flush = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rstn = 1'b0;
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rstn = 1'b0;
      idle_inputs();
      req0_valid = 1'b1; req0_a = 32'hDEAD; req0_wb = 1'b1;
      req1_valid = 1'b1; req1_a = 32'hBEEF; req1_wb = 1'b1;
      #1;
      n_checks++; if (req0_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready0: got %b exp 0", req0_ready); end
      n_checks++; if (req1_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready1: got %b exp 0", req1_ready); end
      n_checks++; if (alu_a !== 32'd0) begin n_errors++; $display("FAIL reset_alu_a: got %h exp 0", alu_a); end
      n_checks++; if (alu_wb !== 1'b0) begin n_errors++; $display("FAIL reset_alu_wb: got %b exp 0", alu_wb); end
      @(negedge clk);
      #1;
      n_checks++; if ({rsp0_valid, rsp1_valid, rsp_wb} !== 3'b000) begin n_errors++; $display("FAIL reset_rsp: got %b exp 000", {rsp0_valid, rsp1_valid, rsp_wb}); end
      @(negedge clk);
      rstn = 1'b1;
      idle_inputs();
   endtask

   task automatic test_single();
      @(negedge clk);
      req0_valid = 1'b1; req0_sel = 4'd0; req0_a = 32'd5; req0_b = 32'd7; req0_dest = 5'd3; req0_wb = 1'b1;
      #1;
      n_checks++; if (req0_ready !== 1'b1) begin n_errors++; $display("FAIL single_ready0: got %b exp 1", req0_ready); end
      n_checks++; if (req1_ready !== 1'b0) begin n_errors++; $display("FAIL single_ready1: got %b exp 0", req1_ready); end
      n_checks++; if (rsp1_valid !== 1'b0) begin n_errors++; $display("FAIL single_rsp1_a: got %b exp 0", rsp1_valid); end
      @(negedge clk);
      idle_inputs();
      #1;
      n_checks++; if (rsp0_valid !== 1'b1) begin n_errors++; $display("FAIL single_rsp0: got %b exp 1", rsp0_valid); end
      n_checks++; if (rsp1_valid !== 1'b0) begin n_errors++; $display("FAIL single_rsp1_b: got %b exp 0", rsp1_valid); end
      n_checks++; if (rsp_res !== 32'd12) begin n_errors++; $display("FAIL single_res: got %0d exp 12", rsp_res); end
      n_checks++; if (rsp_dest !== 5'd3) begin n_errors++; $display("FAIL single_dest: got %0d exp 3", rsp_dest); end
      n_checks++; if (rsp_wb !== 1'b1) begin n_errors++; $display("FAIL single_wb: got %b exp 1", rsp_wb); end
      n_checks++; if (rsp_eq !== 1'b0) begin n_errors++; $display("FAIL single_eq: got %b exp 0", rsp_eq); end
      @(negedge clk);
      #1;
      n_checks++; if ({rsp0_valid, rsp1_valid, rsp_wb} !== 3'b000) begin n_errors++; $display("FAIL single_after: got %b exp 000", {rsp0_valid, rsp1_valid, rsp_wb}); end
   endtask

   // Both ports valid for 4 cycles from rr_ptr=0. A port advances to its next
   // request only after being granted: port0 a=10+k, port1 a=100+k.
   task automatic test_back_to_back();
      logic        g0, p0;
      logic [31:0] exp_a, exp_res;
      logic [4:0]  exp_dest;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i < 4) begin
            req0_valid = 1'b1; req0_sel = 4'd0; req0_a = 32'(10 + ((i + 1) >> 1)); req0_b = 32'd1;
            req0_dest = 5'((i + 1) >> 1); req0_wb = 1'b1;
            req1_valid = 1'b1; req1_sel = 4'd1; req1_a = 32'(100 + (i >> 1)); req1_b = 32'd50;
            req1_dest = 5'(16 + (i >> 1)); req1_wb = 1'b0;
         end else begin
            idle_inputs();
         end
         #1;
         if (i < 4) begin
            g0    = ((i % 2) == 0);
            exp_a = g0 ? 32'(10 + (i >> 1)) : 32'(100 + (i >> 1));
            n_checks++; if ({req0_ready, req1_ready} !== {g0, ~g0}) begin n_errors++; $display("FAIL b2b_grant[%0d]: got %b%b exp %b%b", i, req0_ready, req1_ready, g0, ~g0); end
            n_checks++; if (alu_a !== exp_a) begin n_errors++; $display("FAIL b2b_alu_a[%0d]: got %0d exp %0d", i, alu_a, exp_a); end
         end
         if (i > 0) begin
            p0       = (((i - 1) % 2) == 0);
            exp_res  = p0 ? 32'(11 + ((i - 1) >> 1)) : 32'(50 + ((i - 1) >> 1));
            exp_dest = p0 ? 5'((i - 1) >> 1) : 5'(16 + ((i - 1) >> 1));
            n_checks++; if ({rsp0_valid, rsp1_valid} !== {p0, ~p0}) begin n_errors++; $display("FAIL b2b_rsp[%0d]: got %b%b exp %b%b", i, rsp0_valid, rsp1_valid, p0, ~p0); end
            n_checks++; if (rsp_res !== exp_res) begin n_errors++; $display("FAIL b2b_res[%0d]: got %0d exp %0d", i, rsp_res, exp_res); end
            n_checks++; if (rsp_dest !== exp_dest) begin n_errors++; $display("FAIL b2b_dest[%0d]: got %0d exp %0d", i, rsp_dest, exp_dest); end
            n_checks++; if (rsp_wb !== p0) begin n_errors++; $display("FAIL b2b_wb[%0d]: got %b exp %b", i, rsp_wb, p0); end
         end
      end
   endtask

   task automatic test_rr_after_port1();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         req1_valid = 1'b1; req1_sel = 4'd0; req1_a = 32'(i); req1_b = 32'(i); req1_dest = 5'(i + 1); req1_wb = 1'b1;
         #1;
         n_checks++; if ({req0_ready, req1_ready} !== 2'b01) begin n_errors++; $display("FAIL rr1_grant[%0d]: got %b%b exp 01", i, req0_ready, req1_ready); end
         if (i > 0) begin
            n_checks++; if ({rsp1_valid, rsp_eq} !== 2'b11) begin n_errors++; $display("FAIL rr1_rsp[%0d]: got %b%b exp 11", i, rsp1_valid, rsp_eq); end
         end
      end
      @(negedge clk);
      req0_valid = 1'b1; req0_sel = 4'd0; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; req0_dest = 5'd7; req0_wb = 1'b1;
      req1_a = 32'd9; req1_b = 32'd4; req1_dest = 5'd8;
      #1;
      n_checks++; if ({req0_ready, req1_ready} !== 2'b10) begin n_errors++; $display("FAIL rr1_conflict: got %b%b exp 10", req0_ready, req1_ready); end
      @(negedge clk);
      req0_valid = 1'b0;
      #1;
      n_checks++; if (req1_ready !== 1'b1) begin n_errors++; $display("FAIL rr1_ready1: got %b exp 1", req1_ready); end
      n_checks++; if ({rsp0_valid, rsp_ovf} !== 2'b11) begin n_errors++; $display("FAIL rr1_ovf: got %b%b exp 11", rsp0_valid, rsp_ovf); end
      n_checks++; if (rsp_res !== 32'd0 || rsp_dest !== 5'd7) begin n_errors++; $display("FAIL rr1_res: got %0d/%0d exp 0/7", rsp_res, rsp_dest); end
      @(negedge clk);
      idle_inputs();
      #1;
      n_checks++; if (rsp1_valid !== 1'b1 || rsp_res !== 32'd13) begin n_errors++; $display("FAIL rr1_last: got %b/%0d exp 1/13", rsp1_valid, rsp_res); end
   endtask

   task automatic test_flush();
      @(negedge clk);
      req0_valid = 1'b1; req0_sel = 4'd0; req0_a = 32'd3; req0_b = 32'd4; req0_dest = 5'd9; req0_wb = 1'b1;
      #1;
      n_checks++; if (req0_ready !== 1'b1) begin n_errors++; $display("FAIL flush_grant0: got %b exp 1", req0_ready); end
      @(negedge clk);
      flush = 1'b1;
      req0_a = 32'd20; req0_b = 32'd2;
      req1_valid = 1'b1; req1_sel = 4'd1; req1_a = 32'd30; req1_b = 32'd5; req1_dest = 5'd2; req1_wb = 1'b1;
      #1;
      n_checks++; if ({req0_ready, req1_ready} !== 2'b00) begin n_errors++; $display("FAIL flush_ready: got %b%b exp 00", req0_ready, req1_ready); end
      n_checks++; if ({rsp0_valid, rsp_wb} !== 2'b00) begin n_errors++; $display("FAIL flush_rsp: got %b%b exp 00", rsp0_valid, rsp_wb); end
      n_checks++; if (alu_wb !== 1'b0) begin n_errors++; $display("FAIL flush_alu_wb: got %b exp 0", alu_wb); end
      @(negedge clk);
      flush = 1'b0;
      #1;
      n_checks++; if ({req0_ready, req1_ready} !== 2'b01) begin n_errors++; $display("FAIL flush_resume: got %b%b exp 01", req0_ready, req1_ready); end
      n_checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin n_errors++; $display("FAIL flush_dead: got %b%b exp 00", rsp0_valid, rsp1_valid); end
      @(negedge clk);
      req1_valid = 1'b0;
      #1;
      n_checks++; if (rsp1_valid !== 1'b1 || rsp_res !== 32'd25) begin n_errors++; $display("FAIL flush_rsp1: got %b/%0d exp 1/25", rsp1_valid, rsp_res); end
      n_checks++; if (req0_ready !== 1'b1) begin n_errors++; $display("FAIL flush_ready0: got %b exp 1", req0_ready); end
      @(negedge clk);
      idle_inputs();
      #1;
      n_checks++; if (rsp0_valid !== 1'b1 || rsp_res !== 32'd22) begin n_errors++; $display("FAIL flush_rsp0: got %b/%0d exp 1/22", rsp0_valid, rsp_res); end
   endtask

   task automatic test_reset_midop();
      @(negedge clk);
      req1_valid = 1'b1; req1_sel = 4'd1; req1_a = 32'd8; req1_b = 32'd3; req1_dest = 5'd4; req1_wb = 1'b1;
      #1;
      n_checks++; if (req1_ready !== 1'b1) begin n_errors++; $display("FAIL midrst_grant1: got %b exp 1", req1_ready); end
      @(negedge clk);
      rstn = 1'b0;
      req0_valid = 1'b1; req0_a = 32'd44; req0_b = 32'd1; req0_dest = 5'd6; req0_wb = 1'b1; req0_sel = 4'd2;
      #1;
      n_checks++; if ({req0_ready, req1_ready} !== 2'b00) begin n_errors++; $display("FAIL midrst_ready: got %b%b exp 00", req0_ready, req1_ready); end
      n_checks++; if ({alu_sel, alu_a, alu_b, alu_dest, alu_wb} !== '0) begin n_errors++; $display("FAIL midrst_alu: got %h %h %h %h %b exp all 0", alu_sel, alu_a, alu_b, alu_dest, alu_wb); end
      @(negedge clk);
      #1;
      n_checks++; if ({rsp0_valid, rsp1_valid, rsp_wb} !== 3'b000) begin n_errors++; $display("FAIL midrst_rsp: got %b exp 000", {rsp0_valid, rsp1_valid, rsp_wb}); end
      @(negedge clk);
      rstn = 1'b1;
      #1;
      n_checks++; if ({req0_ready, req1_ready} !== 2'b10) begin n_errors++; $display("FAIL midrst_conflict: got %b%b exp 10", req0_ready, req1_ready); end
      @(negedge clk);
      idle_inputs();
   endtask

`ifdef JEDRO_1_ALU_ARB_PERF_EN
   task automatic test_perf();
      #1;
      n_checks++; if ({perf_g0, perf_g1, perf_cf} !== 96'd0) begin n_errors++; $display("FAIL perf_reset: got %0d %0d %0d exp 0 0 0", perf_g0, perf_g1, perf_cf); end
      test_back_to_back();
      @(negedge clk);
      flush = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge clk);
      idle_inputs();
      #1;
      n_checks++; if (perf_g0 !== 32'd2) begin n_errors++; $display("FAIL perf_grant0: got %0d exp 2", perf_g0); end
      n_checks++; if (perf_g1 !== 32'd2) begin n_errors++; $display("FAIL perf_grant1: got %0d exp 2", perf_g1); end
      n_checks++; if (perf_cf !== 32'd4) begin n_errors++; $display("FAIL perf_conflict: got %0d exp 4", perf_cf); end
   endtask
`endif

   initial begin
      rstn = 1'b0;
      idle_inputs();
      test_reset();
      test_single();
      apply_reset();
      test_back_to_back();
      apply_reset();
      test_rr_after_port1();
      apply_reset();
      test_flush();
      apply_reset();
      test_reset_midop();
`ifdef JEDRO_1_ALU_ARB_PERF_EN
      apply_reset();
      test_perf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
